// File: rtl/imem_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package imem_fetch_unit_pkg;

  localparam int          BYTES_PER_INSTR  = 4;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_unit_be_word_assembler.sv
// Collects four bytes, most significant first, into a big-endian 32-bit word.
module be_word_assembler
  import imem_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic [7:0]         byte_in,
  output logic [1:0]         cnt,
  output logic               done,
  output logic [INSTR_W-1:0] word
);

  localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_INSTR - 1);

  logic [23:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        sr  <= {sr[15:0], byte_in};
        cnt <= cnt + 2'd1;
      end
    end
  end

  // The final byte is taken straight from memory, so the word completes on the 4th edge.
  assign done = en && (cnt == LAST_CNT) && !clear;
  assign word = {sr, byte_in};

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch: reads byte-wide memory, assembles instructions, hands them
// to decode over valid/ready, and accepts redirects from branch logic.
module imem_fetch_unit
  import imem_fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  output logic [31:0]       pc_plus4
);

  fetch_state_e       state, state_nxt;
  logic [31:0]        pc, pc_nxt;
  logic               valid_nxt;
  logic               load_instr;
  logic [1:0]         cnt;
  logic               done;
  logic [INSTR_W-1:0] word;
  logic               unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  be_word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == FETCH),
    .clear   (redirect_valid),
    .byte_in (mem_rdata),
    .cnt     (cnt),
    .done    (done),
    .word    (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_valid <= valid_nxt;
      if (load_instr) begin
        instr    <= word;
        instr_pc <= pc;
      end
    end
  end

  // Redirect wins over both completion and acceptance.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    valid_nxt  = instr_valid;
    load_instr = 1'b0;
    if (redirect_valid) begin
      pc_nxt    = {redirect_pc[31:2], 2'b00};
      state_nxt = FETCH;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (done) begin
            load_instr = 1'b1;
            valid_nxt  = 1'b1;
            state_nxt  = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc_nxt    = pc + 32'd4;
            valid_nxt = 1'b0;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign mem_addr = pc[ADDR_W-1:0] + ADDR_W'(cnt);
  assign pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed scoreboard bench for imem_fetch_unit.
module tb_imem_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic [31:0] pc_plus4;

  logic [7:0]  mem [32];
  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;

  imem_fetch_unit #(.ADDR_W(5), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .pc_plus4       (pc_plus4)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one complete fetch from an aligned base, checking each byte address.
  task automatic check_fetch(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      chk("mem_addr", 32'(mem_addr), 32'(5'(base[4:0] + 5'(k))));
      chk("valid_low_in_fetch", 32'(instr_valid), 32'd0);
      step();
    end
    chk("valid_after_4_edges", 32'(instr_valid), 32'd1);
    chk("instr_pc_on_valid", instr_pc, base);
  endtask

  // Monitor: every completed handshake is checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: instr %h pc %h, no expected entry", instr, instr_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_instr_pc", instr_pc, e.pc);
        chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}     = 32'h2085_0004;
    {mem[4], mem[5], mem[6], mem[7]}     = 32'hDEAD_BEEF;
    {mem[8], mem[9], mem[10], mem[11]}   = 32'hA1B2_C3D4;
    {mem[16], mem[17], mem[18], mem[19]} = 32'h1122_3344;
    {mem[28], mem[29], mem[30], mem[31]} = 32'hCAFE_BABE;

    // Reset values
    #3 rst_n = 1'b0;
    #20;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    step();
    rst_n = 1'b1;

    // First instruction, accepted immediately
    push(32'h2085_0004, 32'h0);
    check_fetch(32'h0);
    step();

    // Back-pressure for 6 cycles
    instr_ready = 1'b0;
    push(32'hDEAD_BEEF, 32'h4);
    check_fetch(32'h4);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_instr", instr, 32'hDEAD_BEEF);
      chk("bp_instr_pc", instr_pc, 32'h4);
    end
    instr_ready = 1'b1;
    step();

    // Redirect at cnt=2 discards the partial word from 0x8
    chk("fetch8_addr0", 32'(mem_addr), 32'h8);
    step();
    step();
    chk("fetch8_addr2", 32'(mem_addr), 32'hA);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0012;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid_low", 32'(instr_valid), 32'd0);
    push(32'h1122_3344, 32'h10);
    check_fetch(32'h10);

    // Redirect and accept in the same HOLD cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    push(32'hA1B2_C3D4, 32'h8);
    check_fetch(32'h8);
    step();

    // Memory address wrap from 0x1C to 0x20
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C;
    step();
    redirect_valid = 1'b0;
    push(32'hCAFE_BABE, 32'h1C);
    check_fetch(32'h1C);
    step();
    push(32'h2085_0004, 32'h20);
    check_fetch(32'h20);
    step();

    // 32-bit pc wrap, unaligned redirect bits dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFD;
    step();
    redirect_valid = 1'b0;
    push(32'hCAFE_BABE, 32'hFFFF_FFFC);
    check_fetch(32'hFFFF_FFFC);
    step();
    chk("pc_wrap_addr", 32'(mem_addr), 32'h0);

    // Async reset while holding a valid instruction
    instr_ready = 1'b0;
    check_fetch(32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hold_valid", 32'(instr_valid), 32'd0);
    chk("async_hold_instr", instr, 32'h0);
    chk("async_hold_addr", 32'(mem_addr), 32'h0);
    step();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    push(32'h2085_0004, 32'h0);
    check_fetch(32'h0);
    step();

    // Async reset mid-fetch
    step();
    step();
    chk("midfetch_addr", 32'(mem_addr), 32'h6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_fetch_addr", 32'(mem_addr), 32'h0);
    chk("async_fetch_pc_plus4", pc_plus4, 32'h4);
    step();
    rst_n = 1'b1;
    push(32'h2085_0004, 32'h0);
    check_fetch(32'h0);
    step();
    step();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
